// File: rtl/fetch_buffer_pkg.sv
// Shared constants and types for the instruction prefetch queue.
package fetch_buffer_pkg;

    localparam int          HW_W     = 16;
    localparam logic [31:0] NOP_INST = 32'h0000_0033;
    localparam logic [1:0]  OP_32    = 2'b11;

    // Up to two halfwords written per cycle; d0 lands first in program order.
    typedef struct packed {
        logic [1:0]      n;
        logic [HW_W-1:0] d0;
        logic [HW_W-1:0] d1;
    } push_t;

    function automatic logic is_32(input logic [HW_W-1:0] h);
        return h[1:0] == OP_32;
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Memory fetch port, redirect input and instruction output of the prefetch queue.
interface fetch_buffer_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_is_16;

    modport master (
        output mem_req, mem_addr, inst_valid, inst_out, inst_pc, inst_is_16,
        input  mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst_out, inst_pc, inst_is_16,
        output mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_buffer_queue.sv
// Circular halfword FIFO: 0/1/2 pushes and 0/1/2 pops per cycle, with clear.
module fetch_queue
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  push_t                    push,
    input  logic [1:0]               pop_n,
    output logic [HW_W-1:0]          h0,
    output logic [HW_W-1:0]          h1,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [HW_W-1:0] mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    assign h0 = mem[rd_ptr];
    assign h1 = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push.n);
            rd_ptr <= rd_ptr + AW'(pop_n);
            count  <= count + (AW+1)'(push.n) - (AW+1)'(pop_n);
        end
    end

    // Storage needs no reset: nothing is read until count says it was written.
    always_ff @(posedge clk) begin
        if (!(rst || clr)) begin
            if (push.n != 2'd0) mem[wr_ptr] <= push.d0;
            if (push.n == 2'd2) mem[wr_ptr + AW'(1)] <= push.d1;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch queue: fetches aligned words, hands out whole 16/32-bit
// instructions from the queue head, and flushes on PC redirect.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = NOP_INST
) (
    input  logic          clk,
    input  logic          rst,
    fetch_buffer_if.master bus
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]     fetch_addr;
    logic [31:0]     head_pc;
    logic            outstanding;
    logic            stale;
    logic            discard_lo;
    logic [HW_W-1:0] h0;
    logic [HW_W-1:0] h1;
    logic [AW:0]     count;
    push_t           push;
    logic [1:0]      pop_n;
    logic            grant;
    logic            accept;
    logic            h0_is_32;
    logic            valid;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.redirect),
        .push  (push),
        .pop_n (pop_n),
        .h0    (h0),
        .h1    (h1),
        .count (count)
    );

    // Two free slots reserved at request time, so the response always fits.
    assign bus.mem_req  = !rst && !outstanding && !bus.redirect &&
                          ((AW+1)'(DEPTH) - count >= (AW+1)'(2));
    assign bus.mem_addr = fetch_addr;
    assign grant        = bus.mem_req && bus.mem_gnt;
    assign accept       = bus.mem_rvalid && outstanding && !stale && !bus.redirect;

    always_comb begin
        push = '0;
        if (accept) begin
            if (discard_lo) begin
                push.n  = 2'd1;
                push.d0 = bus.mem_rdata[31:16];
            end else begin
                push.n  = 2'd2;
                push.d0 = bus.mem_rdata[15:0];
                push.d1 = bus.mem_rdata[31:16];
            end
        end
    end

    assign h0_is_32       = is_32(h0);
    assign valid          = !rst && (count != '0) && (!h0_is_32 || count >= (AW+1)'(2));
    assign bus.inst_valid = valid;
    assign bus.inst_out   = !valid ? NOP : (h0_is_32 ? {h1, h0} : {16'h0, h0});
    assign bus.inst_is_16 = valid && !h0_is_32;
    assign bus.inst_pc    = head_pc;
    assign pop_n          = (valid && bus.inst_ready && !bus.redirect) ?
                            (h0_is_32 ? 2'd2 : 2'd1) : 2'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_addr  <= {RESET_PC[31:2], 2'b00};
            head_pc     <= RESET_PC;
            outstanding <= 1'b0;
            stale       <= 1'b0;
            discard_lo  <= RESET_PC[1];
        end else begin
            if (bus.mem_rvalid) begin
                outstanding <= 1'b0;
                stale       <= 1'b0;
            end
            if (grant) outstanding <= 1'b1;
            if (bus.redirect) begin
                head_pc    <= {bus.redirect_pc[31:1], 1'b0};
                fetch_addr <= {bus.redirect_pc[31:2], 2'b00};
                discard_lo <= bus.redirect_pc[1];
                // A response still to come belongs to the old path.
                if (outstanding && !bus.mem_rvalid) stale <= 1'b1;
            end else begin
                if (grant)  fetch_addr <= fetch_addr + 32'd4;
                if (accept) discard_lo <= 1'b0;
                head_pc <= head_pc + 32'({pop_n, 1'b0});
            end
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: bench-owned memory image plus an architectural
// PC-stream model that predicts every delivered instruction.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int          DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOPV     = 32'h0000_0033;

    logic clk = 1'b0;
    logic rst;
    fetch_buffer_if bus();

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOPV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] img [256];
    bit          gnt_always;
    bit          pend;
    logic [31:0] model_pc;
    logic [31:0] exp_fetch;
    int          idle;
    logic        smp_valid, smp_req, smp_16;
    logic [31:0] smp_out, smp_pc, smp_addr;
    logic [31:0] cons_pc[$];
    logic [31:0] cons_out[$];
    bit          cons_16[$];

    function automatic logic [15:0] hw_at(input logic [31:0] pc);
        logic [31:0] w;
        w = img[pc[9:2]];
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    // Instruction the architectural stream holds at pc.
    function automatic logic [31:0] inst_at(input logic [31:0] pc, output logic is16);
        logic [15:0] h;
        h = hw_at(pc);
        is16 = (h[1:0] != 2'b11);
        return is16 ? {16'h0, h} : {hw_at(pc + 32'd2), h};
    endfunction

    task automatic fill_img(input bit rnd);
        for (int i = 0; i < 256; i++) img[i] = rnd ? $urandom : 32'h0000_0013;
    endtask

    task automatic clear_log();
        cons_pc.delete(); cons_out.delete(); cons_16.delete();
    endtask

    // One clock: drive grant, sample at negedge, check against the model, step it.
    task automatic cycle();
        logic [31:0] eo;
        logic        e16;
        bit          nxt;
        logic [31:0] naddr;
        nxt = 1'b0;
        naddr = '0;
        bus.mem_gnt = gnt_always ? 1'b1 : ($urandom_range(3) != 0);
        @(negedge clk);
        smp_valid = bus.inst_valid; smp_req = bus.mem_req; smp_16 = bus.inst_is_16;
        smp_out = bus.inst_out; smp_pc = bus.inst_pc; smp_addr = bus.mem_addr;
        checks++;
        if (dut.u_queue.count > DEPTH) begin
            errors++; $display("FAIL overflow: count=%0d limit=%0d", dut.u_queue.count, DEPTH);
        end
        if (rst) begin
            checks++;
            if (smp_req !== 1'b0 || smp_valid !== 1'b0 || smp_out !== NOPV || smp_16 !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: req=%b valid=%b out=%h is16=%b want 0 0 %h 0",
                         smp_req, smp_valid, smp_out, smp_16, NOPV);
            end
            model_pc = RESET_PC & ~32'h1; exp_fetch = {RESET_PC[31:2], 2'b00}; idle = 0;
        end else begin
            checks++;
            if (smp_req && bus.redirect) begin
                errors++; $display("FAIL req_during_redirect: mem_req=1 want 0");
            end
            if (smp_req) begin
                checks++;
                if (smp_addr !== exp_fetch) begin
                    errors++; $display("FAIL mem_addr: got %h want %h", smp_addr, exp_fetch);
                end
                checks++;
                if (pend) begin
                    errors++; $display("FAIL one_outstanding: mem_req=1 while response due, want 0");
                end
            end
            if (smp_valid) begin
                eo = inst_at(model_pc, e16);
                idle = 0;
                checks++;
                if (smp_pc !== model_pc) begin
                    errors++; $display("FAIL inst_pc: got %h want %h", smp_pc, model_pc);
                end
                checks++;
                if (smp_out !== eo || smp_16 !== e16) begin
                    errors++;
                    $display("FAIL inst_out: got %h/%b want %h/%b at pc %h", smp_out, smp_16, eo, e16, model_pc);
                end
            end else begin
                idle++;
                checks++;
                if (smp_out !== NOPV || smp_16 !== 1'b0) begin
                    errors++; $display("FAIL idle_out: got %h/%b want %h/0", smp_out, smp_16, NOPV);
                end
            end
            checks++;
            if (idle == 41) begin
                errors++; $display("FAIL watchdog: inst_valid low %0d cycles, want <=40", idle);
            end
            if (bus.redirect) begin
                model_pc  = bus.redirect_pc & ~32'h1;
                exp_fetch = {bus.redirect_pc[31:2], 2'b00};
                idle = 0;
            end else if (smp_valid && bus.inst_ready) begin
                cons_pc.push_back(smp_pc); cons_out.push_back(smp_out); cons_16.push_back(smp_16);
                model_pc = model_pc + (e16 ? 32'd2 : 32'd4);
            end
            nxt = smp_req && bus.mem_gnt;
            naddr = smp_addr;
            if (nxt) exp_fetch = exp_fetch + 32'd4;
        end
        @(posedge clk); #1;
        pend = nxt;
        bus.mem_rvalid = nxt;
        bus.mem_rdata  = nxt ? img[naddr[9:2]] : $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b1; cycle(); rst = 1'b0; clear_log();
    endtask

    task automatic wait_pend();
        int n;
        n = 0;
        while (!pend && n < 20) begin cycle(); n++; end
        checks++;
        if (!pend) begin errors++; $display("FAIL wait_outstanding: pend=0 want 1"); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cycle();
        checks++;
        if (smp_pc !== RESET_PC) begin
            errors++; $display("FAIL reset_pc: got %h want %h", smp_pc, RESET_PC);
        end
    endtask

    task automatic test_first_fetch();
        int first;
        first = -1;
        fill_img(0);
        img[0] = 32'h0050_0093; img[1] = 32'h0010_0113;
        gnt_always = 1'b1; bus.inst_ready = 1'b1;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (smp_valid && first < 0) first = k;
        end
        checks++;
        if (first !== 3) begin errors++; $display("FAIL first_latency: got %0d want 3", first); end
        checks++;
        if (cons_pc.size() < 2) begin
            errors++; $display("FAIL first_count: got %0d want >=2", cons_pc.size());
        end else begin
            checks++;
            if (cons_pc[0] !== 32'h0 || cons_out[0] !== 32'h0050_0093 || cons_16[0] !== 1'b0) begin
                errors++; $display("FAIL first_inst0: got %h@%h want 00500093@0", cons_out[0], cons_pc[0]);
            end
            checks++;
            if (cons_pc[1] !== 32'h4 || cons_out[1] !== 32'h0010_0113 || cons_16[1] !== 1'b0) begin
                errors++; $display("FAIL first_inst1: got %h@%h want 00100113@4", cons_out[1], cons_pc[1]);
            end
        end
    endtask

    task automatic test_mixed();
        fill_img(0);
        img[0] = 32'h0093_4505; img[1] = 32'h0000_0050;
        do_reset();
        repeat (10) cycle();
        checks++;
        if (cons_pc.size() < 2) begin
            errors++; $display("FAIL mixed_count: got %0d want >=2", cons_pc.size());
        end else begin
            checks++;
            if (cons_pc[0] !== 32'h0 || cons_out[0] !== 32'h0000_4505 || cons_16[0] !== 1'b1) begin
                errors++; $display("FAIL mixed_c16: got %h/%b@%h want 00004505/1@0", cons_out[0], cons_16[0], cons_pc[0]);
            end
            checks++;
            if (cons_pc[1] !== 32'h2 || cons_out[1] !== 32'h0050_0093 || cons_16[1] !== 1'b0) begin
                errors++; $display("FAIL mixed_straddle: got %h/%b@%h want 00500093/0@2", cons_out[1], cons_16[1], cons_pc[1]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] ref_out, ref_pc;
        int n;
        fill_img(1);
        do_reset();
        n = 0;
        do begin cycle(); n++; end while (!smp_valid && n < 20);
        bus.inst_ready = 1'b0;
        cycle();
        ref_out = smp_out; ref_pc = smp_pc;
        for (int k = 1; k < 10; k++) begin
            cycle();
            checks++;
            if (smp_valid !== 1'b1 || smp_out !== ref_out || smp_pc !== ref_pc) begin
                errors++; $display("FAIL stall_hold: got %b %h@%h want 1 %h@%h", smp_valid, smp_out, smp_pc, ref_out, ref_pc);
            end
        end
        checks++;
        if (dut.u_queue.count < DEPTH - 1 || bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL stall_full: count=%0d req=%b want >=%0d and 0", dut.u_queue.count, bus.mem_req, DEPTH - 1);
        end
        clear_log();
        bus.inst_ready = 1'b1;
        repeat (40) cycle();
        checks++;
        if (cons_pc.size() == 0 || cons_pc[0] !== ref_pc) begin
            errors++; $display("FAIL stall_release: first pc %h want %h", cons_pc.size() ? cons_pc[0] : 32'hx, ref_pc);
        end
    endtask

    task automatic test_redirect_outstanding();
        logic [31:0] eo;
        logic        e16;
        int          first;
        fill_img(1);
        do_reset();
        repeat (6) cycle();
        wait_pend();
        bus.inst_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0102;
        cycle();
        bus.redirect = 1'b0; bus.inst_ready = 1'b1;
        clear_log();
        first = -1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (k == 1) begin
                checks++;
                if (smp_req !== 1'b1 || smp_addr !== 32'h100) begin
                    errors++; $display("FAIL redir_addr: req=%b addr=%h want 1 00000100", smp_req, smp_addr);
                end
            end
            if (smp_valid && first < 0) first = k;
        end
        checks++;
        if (first !== 3) begin errors++; $display("FAIL redir_latency: got %0d want 3", first); end
        eo = inst_at(32'h102, e16);
        checks++;
        if (cons_pc.size() == 0 || cons_pc[0] !== 32'h102 || cons_out[0] !== eo) begin
            errors++; $display("FAIL redir_first: got %h@%h want %h@102",
                               cons_out.size() ? cons_out[0] : 32'hx, cons_pc.size() ? cons_pc[0] : 32'hx, eo);
        end
    endtask

    task automatic test_redirect_rvalid();
        fill_img(1);
        do_reset();
        repeat (8) cycle();
        wait_pend();
        bus.inst_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0205;
        cycle();
        bus.redirect = 1'b0;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.inst_pc !== 32'h204 || dut.u_queue.count !== 0) begin
            errors++; $display("FAIL redir_rvalid: valid=%b pc=%h count=%0d want 0 00000204 0",
                               bus.inst_valid, bus.inst_pc, dut.u_queue.count);
        end
        repeat (20) cycle();
    endtask

    task automatic test_reset_midstream();
        fill_img(1);
        do_reset();
        repeat (8) cycle();
        wait_pend();
        rst = 1'b1;
        cycle();
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.inst_out !== NOPV || bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL mid_reset: valid=%b out=%h req=%b want 0 %h 0", bus.inst_valid, bus.inst_out, bus.mem_req, NOPV);
        end
        fill_img(1);
        rst = 1'b0;
        clear_log();
        repeat (30) cycle();
        checks++;
        if (cons_pc.size() == 0 || cons_pc[0] !== RESET_PC) begin
            errors++; $display("FAIL mid_reset_restart: first pc %h want %h", cons_pc.size() ? cons_pc[0] : 32'hx, RESET_PC);
        end
    endtask

    task automatic test_random();
        fill_img(1);
        gnt_always = 1'b0;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            bus.inst_ready  = ($urandom_range(3) != 0);
            bus.redirect    = ($urandom_range(19) == 0);
            bus.redirect_pc = $urandom;
            cycle();
        end
        bus.redirect = 1'b0;
        checks++;
        if (cons_pc.size() < 500) begin
            errors++; $display("FAIL random_throughput: consumed %0d want >=500", cons_pc.size());
        end
    endtask

    initial begin
        rst = 1'b1; pend = 1'b0; gnt_always = 1'b1; idle = 0;
        model_pc = RESET_PC; exp_fetch = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.inst_ready = 1'b0;
        fill_img(0);
        test_reset();
        test_first_fetch();
        test_mixed();
        test_stall();
        test_redirect_outstanding();
        test_redirect_rvalid();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
Instruction prefetch queue that sits upstream of the IF/ID pipeline register.
- Fetches aligned 32-bit words from the unified memory instruction port and stores them as halfwords in a circular queue.
- Presents one whole instruction per cycle: 32-bit, or 16-bit compressed (raw, not expanded).
- Handles PC redirects from branch, jump and system resolution.
- Drops in-flight fetches that are stale after a redirect.

Parameters:
DEPTH, 8, queue capacity in halfwords; power of 2, minimum 4.
RESET_PC, 32'h0000_0000, fetch and output PC after reset.
NOP, 32'h0000_0033, value driven on inst_out when inst_valid=0.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
mem_req  out  1  request one instruction word
mem_addr  out  32  word address of the request; bits [1:0] always 0
mem_gnt  in  1  memory accepted the request this cycle
mem_rvalid  in  1  read data valid; asserted exactly 1 cycle after a grant
mem_rdata  in  32  read word, little-endian
redirect  in  1  flush the queue and refetch from redirect_pc
redirect_pc  in  32  new PC; bit 0 ignored
inst_ready  in  1  IF/ID accepts an instruction this cycle; 0 means stall
inst_valid  out  1  inst_out holds a complete instruction
inst_out  out  32  instruction; upper 16 bits are zero when 16-bit
inst_pc  out  32  PC of inst_out
inst_is_16  out  1  inst_out is a compressed instruction

Behaviour:
Reset (already decided): one clock, clk; rst is synchronous and active-high.
- Reset values: queue empty, count=0, fetch_addr={RESET_PC[31:2],2'b00}, head_pc=RESET_PC, no fetch outstanding.
- Outputs during and after reset: mem_req=0, inst_valid=0, inst_out=NOP, inst_is_16=0, inst_pc=RESET_PC.
- If RESET_PC[1]=1, the low halfword of the first returned word is discarded.

Fetch:
- At most one request outstanding.
- mem_req=1 when: no fetch outstanding, and free slots (DEPTH-count) >= 2, and redirect=0.
- mem_addr=fetch_addr. On mem_gnt, fetch_addr += 4 (wraps modulo 2^32) and the request becomes outstanding.
- mem_req stays asserted, with mem_addr held, until granted.

Response:
- On mem_rvalid with a non-stale fetch, push rdata[15:0] then rdata[31:16] into the queue.
- Exception: skip rdata[15:0] when the discard-low flag is set; clear the flag after that push.
- Pointers wrap modulo DEPTH.

Output assembly (combinational from the queue head):
- h0 = head halfword, h1 = next halfword.
- If count>=1 and h0[1:0]!=2'b11: inst_valid=1, inst_is_16=1, inst_out={16'h0,h0}.
- If h0[1:0]==2'b11: inst_valid=1 only when count>=2; inst_out={h1,h0}, inst_is_16=0.
- Otherwise inst_valid=0 and inst_out=NOP.
- inst_pc=head_pc.

Consume:
- Happens when inst_valid and inst_ready.
- Pop 1 or 2 halfwords; head_pc += 2 or 4.
- Push and pop in the same cycle are legal; count updates by the net amount.
- count never exceeds DEPTH. The free-slot check guarantees this; an overflow is a design error and the bench asserts on it.

Redirect (priority over everything else in that cycle):
- Queue cleared, count=0, head_pc=redirect_pc & ~1, fetch_addr={redirect_pc[31:2],2'b00}, discard-low = redirect_pc[1].
- No consume is performed that cycle and inst_valid is ignored by the consumer.
- mem_req=0 that cycle.
- If a fetch is outstanding or granted that cycle, mark it stale; its mem_rvalid data is dropped with no push.
- A redirect arriving together with mem_rvalid also drops that data.
- The first request to the new address is issued the next cycle.
- Back-to-back redirects: the last one wins.

Latency:
- Redirect to first inst_valid is 3 cycles with an immediate grant: request at cycle +1, data at +2, valid at +2 combinationally after the push registers, i.e. visible at +3.

Decomposition:
- Shared defines file: the NOP constant, the 2'b11 "32-bit instruction" opcode test, and the halfword width.
- One sub-module, fetch_queue: a circular halfword FIFO with 2-wide push, 1/2 pop, count, and clear.
- Fetch control, stale tracking, and output assembly stay in fetch_buffer.

Test Plan:
1. Reset with RESET_PC=0; memory returns 32'h00500093 then 32'h00100113 with gnt always 1 -> inst_valid 3 cycles after rst deasserts; inst_out=00500093, inst_pc=0, then 00100113 at pc=4; inst_is_16=0.
2. Mixed stream, words 32'h0093_4505 then 32'h0000_0050 -> 16-bit 4505 @0 (inst_is_16=1, inst_out=0000_4505), then 32-bit 0050_0093 @2 straddling words.
3. inst_ready=0 for 10 cycles -> count saturates at DEPTH or DEPTH-1, mem_req drops, no overflow, inst_out and inst_pc held stable; on release, in-order consumption with no lost halfword.
4. Redirect to 32'h0000_0102 while a fetch is outstanding -> stale data dropped; next mem_addr=0x100; upper halfword of that word delivered with inst_pc=0x102.
5. Redirect asserted in the same cycle as mem_rvalid and inst_ready -> no push, no pop; head_pc=redirect_pc; inst_valid=0 the next cycle.
6. rst asserted mid-stream with a fetch outstanding -> next cycle inst_valid=0, inst_out=NOP, mem_req=0; the late mem_rvalid is ignored.
